// File: rtl/fifo_req_arbiter_if.sv
// Handshake bundle between producer/consumer requesters, the FIFO pointer
// controller status, and the request arbiter.
interface fifo_req_arbiter_if;

    // Requester side
    logic push_req;
    logic pop_req;

    // Pointer controller status
    logic full;
    logic emp;

    // Strobes toward the pointer controller
    logic wr;
    logic rd;

    // Acknowledges back to the requesters
    logic push_ack;
    logic pop_ack;

    // Arbitration and stall status
    logic last_grant;
    logic push_stall;
    logic pop_stall;

    // Environment side: drives requests and status, observes strobes
    modport master (
        output push_req,
        output pop_req,
        output full,
        output emp,
        input  wr,
        input  rd,
        input  push_ack,
        input  pop_ack,
        input  last_grant,
        input  push_stall,
        input  pop_stall
    );

    // Arbiter side
    modport slave (
        input  push_req,
        input  pop_req,
        input  full,
        input  emp,
        output wr,
        output rd,
        output push_ack,
        output pop_ack,
        output last_grant,
        output push_stall,
        output pop_stall
    );

endinterface

// File: rtl/fifo_req_arbiter.sv
// Push/pop request arbiter feeding the FIFO pointer controller.
// Produces mutually exclusive one-cycle wr/rd strobes, alternates priority
// under contention, inserts one idle cycle after every grant so full/emp
// settle, and flags requests blocked for STALL_LIMIT consecutive cycles.
module fifo_req_arbiter #(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_req_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

    // Registered state
    logic             wr_q,         wr_d;
    logic             rd_q,         rd_d;
    logic             push_ack_q,   push_ack_d;
    logic             pop_ack_q,    pop_ack_d;
    logic             last_grant_q, last_grant_d;
    logic             holdoff_q,    holdoff_d;
    logic [CNT_W-1:0] push_cnt_q,   push_cnt_d;
    logic [CNT_W-1:0] pop_cnt_q,    pop_cnt_d;
    logic             push_stall_q, push_stall_d;
    logic             pop_stall_q,  pop_stall_d;

    // Arbitration intermediates
    logic w_ok;
    logic r_ok;
    logic grant_w;
    logic grant_r;

    // Saturating blocked-cycle counter step; clears when granted or idle
    function automatic logic [CNT_W-1:0] stall_step(
        input logic             req,
        input logic             granted,
        input logic [CNT_W-1:0] cnt
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (!req || granted) begin
            nxt = '0;
        end else if (cnt != CNT_MAX) begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    // Eligibility and priority selection; a tie goes opposite to last grant
    always_comb begin
        w_ok    = bus.push_req & ~bus.full & ~holdoff_q;
        r_ok    = bus.pop_req  & ~bus.emp  & ~holdoff_q;
        grant_w = w_ok & (~r_ok |  last_grant_q);
        grant_r = r_ok & (~w_ok | ~last_grant_q);
    end

    // Next-state for strobes, acks, priority, holdoff and stall tracking
    always_comb begin
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        push_ack_d   = 1'b0;
        pop_ack_d    = 1'b0;
        last_grant_d = last_grant_q;
        holdoff_d    = 1'b0;

        if (grant_w) begin
            wr_d         = 1'b1;
            push_ack_d   = 1'b1;
            last_grant_d = 1'b0;
            holdoff_d    = 1'b1;
        end else if (grant_r) begin
            rd_d         = 1'b1;
            pop_ack_d    = 1'b1;
            last_grant_d = 1'b1;
            holdoff_d    = 1'b1;
        end

        push_cnt_d   = stall_step(bus.push_req, grant_w, push_cnt_q);
        pop_cnt_d    = stall_step(bus.pop_req,  grant_r, pop_cnt_q);
        push_stall_d = (push_cnt_d == CNT_MAX);
        pop_stall_d  = (pop_cnt_d  == CNT_MAX);
    end

    // State register; reset clears everything at once, mid-pulse included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            push_ack_q   <= 1'b0;
            pop_ack_q    <= 1'b0;
            last_grant_q <= 1'b1;
            holdoff_q    <= 1'b0;
            push_cnt_q   <= '0;
            pop_cnt_q    <= '0;
            push_stall_q <= 1'b0;
            pop_stall_q  <= 1'b0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            push_ack_q   <= push_ack_d;
            pop_ack_q    <= pop_ack_d;
            last_grant_q <= last_grant_d;
            holdoff_q    <= holdoff_d;
            push_cnt_q   <= push_cnt_d;
            pop_cnt_q    <= pop_cnt_d;
            push_stall_q <= push_stall_d;
            pop_stall_q  <= pop_stall_d;
        end
    end

    // Output drive straight from flops
    assign bus.wr         = wr_q;
    assign bus.rd         = rd_q;
    assign bus.push_ack   = push_ack_q;
    assign bus.pop_ack    = pop_ack_q;
    assign bus.last_grant = last_grant_q;
    assign bus.push_stall = push_stall_q;
    assign bus.pop_stall  = pop_stall_q;

    // The controller must never see a write and a read in the same cycle
    a_excl: assert property (@(posedge clk) disable iff (rst) !(wr_q && rd_q));

endmodule

// File: tb/tb_fifo_req_arbiter.sv
// Directed bench for fifo_req_arbiter: stimulus pushes hand-computed
// expected outputs per cycle into a queue; a monitor pops and compares
// after each rising edge and also checks the per-cycle invariants.
module tb_fifo_req_arbiter;

    typedef struct packed {
        logic wr;
        logic rd;
        logic lg;
        logic ps;
        logic qs;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    fifo_req_arbiter_if bus ();

    fifo_req_arbiter #(.STALL_LIMIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for the next edge (releasing reset) and queue the outputs
    // expected right after that edge
    task automatic step(input logic p, input logic q, input logic f, input logic e,
                        input logic ewr, input logic erd, input logic elg,
                        input logic eps, input logic eqs);
        exp_t x;
        @(negedge clk);
        rst          = 1'b0;
        bus.push_req = p;
        bus.pop_req  = q;
        bus.full     = f;
        bus.emp      = e;
        x.wr = ewr;
        x.rd = erd;
        x.lg = elg;
        x.ps = eps;
        x.qs = eqs;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        bus.full     = 1'b0;
        bus.emp      = 1'b0;
    endtask

    // Monitor: invariants every cycle, scoreboard pop when an entry is due
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            chk("excl_wr_rd", 32'(bus.wr & bus.rd), 32'd0);
            chk("push_ack_eq_wr", 32'(bus.push_ack), 32'(bus.wr));
            chk("pop_ack_eq_rd", 32'(bus.pop_ack), 32'(bus.rd));
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("wr", 32'(bus.wr), 32'(x.wr));
                chk("rd", 32'(bus.rd), 32'(x.rd));
                chk("last_grant", 32'(bus.last_grant), 32'(x.lg));
                chk("push_stall", 32'(bus.push_stall), 32'(x.ps));
                chk("pop_stall", 32'(bus.pop_stall), 32'(x.qs));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.push_req = 1'b1;
        bus.pop_req  = 1'b0;
        bus.full     = 1'b0;
        bus.emp      = 1'b1;

        // Held reset with a pending push: everything quiet, last_grant=1
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", 32'(bus.wr), 32'd0);
        chk("rst_rd", 32'(bus.rd), 32'd0);
        chk("rst_push_ack", 32'(bus.push_ack), 32'd0);
        chk("rst_pop_ack", 32'(bus.pop_ack), 32'd0);
        chk("rst_last_grant", 32'(bus.last_grant), 32'd1);
        chk("rst_push_stall", 32'(bus.push_stall), 32'd0);
        chk("rst_pop_stall", 32'(bus.pop_stall), 32'd0);

        // First grant right after reset release, then holdoff and idle
        step(1, 0, 0, 1,  1, 0, 0, 0, 0);
        step(0, 0, 0, 1,  0, 0, 0, 0, 0);
        step(0, 0, 0, 1,  0, 0, 0, 0, 0);

        // Contention from reset: W, idle, R, idle, ...
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 0, 0,
                 (k % 4) == 1, (k % 4) == 3, ((k % 4) == 3) || ((k % 4) == 0), 0, 0);
        end
        step(0, 0, 0, 0,  0, 0, 1, 0, 0);

        // Push blocked by full for 20 edges; stall from the 16th
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 1, 0,  0, 0, 1, i >= 16, 0);
        end
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Pop on empty while pushes stream every other cycle
        for (int i = 1; i <= 18; i++) begin
            step(1, 1, 0, 1,  (i % 2) == 1, 0, 0, 0, i >= 16);
        end
        step(1, 1, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0,  0, 0, 1, 0, 0);
        step(1, 1, 0, 0,  1, 0, 0, 0, 0);
        step(1, 1, 0, 0,  0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Single-side streaming: four writes two cycles apart, then nothing
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0, 0,  (i % 2) == 1, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0,  0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Asynchronous reset while a write strobe is high
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_wr", 32'(bus.wr), 32'd0);
        chk("async_push_ack", 32'(bus.push_ack), 32'd0);
        chk("async_holdoff", 32'(dut.holdoff_q), 32'd0);
        chk("async_last_grant", 32'(bus.last_grant), 32'd1);

        // Illegal full and emp together: nothing granted
        step(1, 1, 1, 1,  0, 0, 1, 0, 0);
        step(1, 1, 1, 1,  0, 0, 1, 0, 0);
        step(0, 0, 0, 0,  0, 0, 1, 0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
